// File: rtl/phys_reg_freelist_pkg.sv
// Shared sizing and reset-tag definitions for the physical register free list,
// so rename and retire agree on tag width, list depth and initial contents.
package phys_reg_freelist_pkg;

   localparam int NUM_PHYS_REGS_DEF = 64;
   localparam int NUM_ARCH_REGS_DEF = 32;
   localparam int LOG_PHYS          = $clog2(NUM_PHYS_REGS_DEF);
   localparam int DEPTH             = NUM_PHYS_REGS_DEF - NUM_ARCH_REGS_DEF;

   // Tags below num_arch hold the architectural mapping at reset; entry i starts free.
   function automatic int reset_tag(input int num_arch, input int i);
      return num_arch + i;
   endfunction

endpackage

// File: rtl/phys_reg_freelist_ptr.sv
// Modulo-N pointer register with increment enable; wraps N-1 -> 0 explicitly,
// so N need not be a power of two.
module freelist_ptr
   import phys_reg_freelist_pkg::*;
#(
   parameter  int N_ENTRIES = DEPTH,
   localparam int PW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(N_ENTRIES - 1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags: one grant and one release per cycle.
// Optional same-cycle release-to-grant bypass on an empty list: FREELIST_BYPASS_EN.
module phys_reg_freelist
   import phys_reg_freelist_pkg::*;
#(
   parameter  int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
   parameter  int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
   localparam int L_PHYS        = $clog2(NUM_PHYS_REGS),
   localparam int L_DEPTH       = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              AllocReq_IN,
   output logic              AllocValid_OUT,
   output logic [L_PHYS-1:0] AllocReg_OUT,
   output logic [L_PHYS-1:0] BusyReg_OUT,
   output logic              SetBusy_OUT,
   input  logic              ReleaseValid_IN,
   input  logic [L_PHYS-1:0] ReleaseReg_IN,
   output logic [L_PHYS:0]   Count_OUT,
   output logic              Error_OUT
);

   localparam int            PW       = (L_DEPTH > 1) ? $clog2(L_DEPTH) : 1;
   localparam logic [L_PHYS:0] FULL_CNT = (L_PHYS + 1)'(L_DEPTH);

   logic [L_PHYS-1:0] mem [L_DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [L_PHYS:0]   count;
   logic              error_q;

   logic empty, full, fire, bypass_take, head_inc, release_ok, overflow;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

`ifdef FREELIST_BYPASS_EN
   logic bypass;
   assign bypass         = empty & ReleaseValid_IN;
   assign AllocValid_OUT = !empty | bypass;
   assign AllocReg_OUT   = bypass ? ReleaseReg_IN : mem[head];
   assign bypass_take    = bypass & AllocReq_IN;
`else
   assign AllocValid_OUT = !empty;
   assign AllocReg_OUT   = mem[head];
   assign bypass_take    = 1'b0;
`endif

   assign fire        = AllocReq_IN & AllocValid_OUT;
   assign SetBusy_OUT = fire;
   assign BusyReg_OUT = AllocReg_OUT;

   // A bypassed grant consumes the released tag directly, so neither pointer moves.
   assign head_inc   = fire & !empty;
   assign release_ok = ReleaseValid_IN & (!full | fire) & !bypass_take;
   assign overflow   = ReleaseValid_IN & full & !fire;

   freelist_ptr #(.N_ENTRIES(L_DEPTH)) u_head (
      .clk(CLK), .rst_n(RESET), .inc(head_inc), .ptr(head)
   );

   freelist_ptr #(.N_ENTRIES(L_DEPTH)) u_tail (
      .clk(CLK), .rst_n(RESET), .inc(release_ok), .ptr(tail)
   );

   // NOTE: the tag array is built from resettable flops because its reset
   // contents are the initial free tags; a RAM macro could not provide them.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < L_DEPTH; i++)
            mem[i] <= L_PHYS'(reset_tag(NUM_ARCH_REGS, i));
      end else if (release_ok) begin
         mem[tail] <= ReleaseReg_IN;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count   <= FULL_CNT;
         error_q <= 1'b0;
      end else begin
         count   <= count + (L_PHYS + 1)'(release_ok) - (L_PHYS + 1)'(head_inc);
         error_q <= error_q | overflow;
      end
   end

   assign Count_OUT = count;
   assign Error_OUT = error_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Scoreboard bench for phys_reg_freelist: stimulus queues expected grant tags,
// a negedge monitor pops and compares them whenever SetBusy_OUT is raised.
module tb_phys_reg_freelist;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       AllocReq_IN;
   logic       AllocValid_OUT;
   logic [5:0] AllocReg_OUT;
   logic [5:0] BusyReg_OUT;
   logic       SetBusy_OUT;
   logic       ReleaseValid_IN;
   logic [5:0] ReleaseReg_IN;
   logic [6:0] Count_OUT;
   logic       Error_OUT;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [5:0] sb [$];

   phys_reg_freelist #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(32)) dut (
      .CLK(CLK), .RESET(RESET),
      .AllocReq_IN(AllocReq_IN), .AllocValid_OUT(AllocValid_OUT),
      .AllocReg_OUT(AllocReg_OUT), .BusyReg_OUT(BusyReg_OUT),
      .SetBusy_OUT(SetBusy_OUT), .ReleaseValid_IN(ReleaseValid_IN),
      .ReleaseReg_IN(ReleaseReg_IN), .Count_OUT(Count_OUT),
      .Error_OUT(Error_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change #1 after the rising edge; checks land #2 after it.
   task automatic drive(input logic req, input logic rv, input logic [5:0] rt);
      AllocReq_IN     = req;
      ReleaseValid_IN = rv;
      ReleaseReg_IN   = rt;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic alloc(input logic [5:0] exp_tag);
      sb.push_back(exp_tag);
      drive(1'b1, 1'b0, 6'd0);
      tick();
   endtask

   always @(negedge CLK) begin
      if (RESET === 1'b1 && SetBusy_OUT === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_grant", 32'(AllocReg_OUT), 32'd99);
         end else begin
            logic [5:0] e;
            e = sb.pop_front();
            check("grant_tag", 32'(AllocReg_OUT), 32'(e));
            check("busy_tag", 32'(BusyReg_OUT), 32'(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b0;
      AllocReq_IN = 1'b0; ReleaseValid_IN = 1'b0; ReleaseReg_IN = '0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;
      #1;
      check("rst_valid", 32'(AllocValid_OUT), 32'd1);
      check("rst_reg", 32'(AllocReg_OUT), 32'd32);
      check("rst_count", 32'(Count_OUT), 32'd32);
      check("rst_error", 32'(Error_OUT), 32'd0);
      check("rst_setbusy", 32'(SetBusy_OUT), 32'd0);

      // Drain: tags 32..63 in order, then a request on an empty list is ignored.
      for (int i = 0; i < 32; i++) alloc(6'(32 + i));
      drive(1'b0, 1'b0, 6'd0);
      check("empty_count", 32'(Count_OUT), 32'd0);
      check("empty_valid", 32'(AllocValid_OUT), 32'd0);
      tick();
      drive(1'b1, 1'b0, 6'd0);
      check("empty_req_setbusy", 32'(SetBusy_OUT), 32'd0);
      tick();

      // Release into an empty list with no request.
      drive(1'b0, 1'b1, 6'd40);
`ifdef FREELIST_BYPASS_EN
      check("bypass_valid", 32'(AllocValid_OUT), 32'd1);
      check("bypass_reg", 32'(AllocReg_OUT), 32'd40);
`else
      check("nobypass_valid", 32'(AllocValid_OUT), 32'd0);
`endif
      tick();
      drive(1'b0, 1'b0, 6'd0);
      check("rel40_valid", 32'(AllocValid_OUT), 32'd1);
      check("rel40_reg", 32'(AllocReg_OUT), 32'd40);
      check("rel40_count", 32'(Count_OUT), 32'd1);
      alloc(6'd40);

      // Refill with 32..63; head sits at slot 1, which now holds 32.
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 6'(32 + i));
         tick();
      end
      drive(1'b0, 1'b0, 6'd0);
      check("refill_count", 32'(Count_OUT), 32'd32);
      check("refill_reg", 32'(AllocReg_OUT), 32'd32);

      // Full list: simultaneous grant and release of tag 7.
      sb.push_back(6'd32);
      drive(1'b1, 1'b1, 6'd7);
      tick();
      drive(1'b0, 1'b0, 6'd0);
      check("full_fire_rel_count", 32'(Count_OUT), 32'd32);
      check("full_fire_rel_error", 32'(Error_OUT), 32'd0);
      for (int i = 0; i < 31; i++) alloc(6'(33 + i));
      drive(1'b0, 1'b0, 6'd0);
      check("wrap_reg", 32'(AllocReg_OUT), 32'd7);
      check("wrap_count", 32'(Count_OUT), 32'd1);
      alloc(6'd7);

      // Refill, then overflow with tag 9.
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 6'(32 + i));
         tick();
      end
      drive(1'b0, 1'b0, 6'd0);
      check("prefull_error", 32'(Error_OUT), 32'd0);
      drive(1'b0, 1'b1, 6'd9);
      tick();
      drive(1'b0, 1'b0, 6'd0);
      check("ovf_count", 32'(Count_OUT), 32'd32);
      check("ovf_error", 32'(Error_OUT), 32'd1);

      // Error stays sticky through later traffic; 5 allocs then 3 releases.
      for (int i = 0; i < 5; i++) alloc(6'(32 + i));
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b1, 6'(i));
         tick();
      end
      drive(1'b0, 1'b0, 6'd0);
      check("sticky_error", 32'(Error_OUT), 32'd1);
      check("sticky_count", 32'(Count_OUT), 32'd30);
      for (int i = 0; i < 5; i++) alloc(6'(37 + i));

      // Asynchronous reset mid-cycle with a release in flight.
      drive(1'b0, 1'b1, 6'd50);
      #1 RESET = 1'b0;
      #1;
      check("arst_valid", 32'(AllocValid_OUT), 32'd1);
      check("arst_reg", 32'(AllocReg_OUT), 32'd32);
      check("arst_count", 32'(Count_OUT), 32'd32);
      check("arst_error", 32'(Error_OUT), 32'd0);
      check("arst_setbusy", 32'(SetBusy_OUT), 32'd0);
      @(posedge CLK);
      #1;
      ReleaseValid_IN = 1'b0;
      RESET = 1'b1;
      alloc(6'd32);
      drive(1'b0, 1'b0, 6'd0);
      check("post_rst_count", 32'(Count_OUT), 32'd31);
      check("post_rst_reg", 32'(AllocReg_OUT), 32'd33);

      repeat (3) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
